sb_param_switch: RTL

- Parametrised successor to the fixed 4-side, 4-track, 1-bit switch box.
- Generalises sides, tracks, data width and PE-output count, and keeps the same rotational connectivity rule.
- Adds addressed, double-buffered configuration with an atomic commit, registered readback and optional per-output pipeline registers.
- Sits between routing channels and the PE in each tile of the array.

---
 rtl/sb_param_switch_pkg.sv | 52 +++++
 rtl/sb_param_switch_mux.sv | 30 +++
 rtl/sb_param_switch.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/sb_param_switch_pkg.sv
// -----------------------------------------------------------------------------
// sb_param_pkg
// Shared helpers for the parametrised switch box:
//   - sb_clog2            : ceiling log2 for elaboration-time sizing
//   - sb_n_in             : mux inputs per output (other sides + PE outputs)
//   - sb_sel_w            : select field width (never below 1)
//   - sb_fpw              : select fields packed per 32-bit config word
//   - sb_n_sel_words      : config words needed to hold every select field
//   - sb_src_side/track   : rotational connectivity rule for side inputs
// -----------------------------------------------------------------------------
package sb_param_pkg;

    function automatic int sb_clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

    function automatic int sb_n_in(input int num_sides, input int num_pe);
        return num_sides - 1 + num_pe;
    endfunction

    function automatic int sb_sel_w(input int n_in);
        int c;
        c = sb_clog2(n_in);
        return (c < 1) ? 1 : c;
    endfunction

    function automatic int sb_fpw(input int sel_w);
        return 32 / sel_w;
    endfunction

    function automatic int sb_n_sel_words(input int n_out, input int fpw);
        return (n_out + fpw - 1) / fpw;
    endfunction

    // Side-input i of an output on side s comes from the (i+1)-th side
    // counting around from s.
    function automatic int sb_src_side(input int s, input int i, input int num_sides);
        return (s + 1 + i) % num_sides;
    endfunction

    // Track index rotates with both the output side and the input position.
    function automatic int sb_src_track(input int s, input int t, input int i,
                                        input int num_tracks);
        return (t + s + i) % num_tracks;
    endfunction

endpackage

// File: rtl/sb_param_switch_mux.sv
// -----------------------------------------------------------------------------
// sb_mux_n
// N-way, WIDTH-bit combinational selector. A select value >= N yields zero.
// Ports:
//   data_i  [N*WIDTH-1:0]  input k at [k*WIDTH +: WIDTH]
//   sel_i   [SEL_W-1:0]    input index
//   data_o  [WIDTH-1:0]    selected input, or 0 when sel_i is out of range
// -----------------------------------------------------------------------------
module sb_mux_n
    import sb_param_pkg::*;
#(
    parameter int N     = 4,
    parameter int WIDTH = 1,
    parameter int SEL_W = sb_sel_w(N)
) (
    input  logic [N*WIDTH-1:0] data_i,
    input  logic [SEL_W-1:0]   sel_i,
    output logic [WIDTH-1:0]   data_o
);

    always_comb begin
        data_o = '0;
        for (int i = 0; i < N; i++) begin
            if (32'(sel_i) == 32'(i)) begin
                data_o = data_i[i*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/sb_param_switch.sv
// -----------------------------------------------------------------------------
// sb_param_switch
// Parametrised tile switch box: every output track picks one of the other
// sides' tracks (rotational rule) or a PE output, under an addressed,
// double-buffered configuration with atomic commit.
//
// Optional feature macro: SB_PIPE_REG_EN
//   Defined   : extra config words hold one reg_en bit per output; when set the
//               output is a register of the mux result (1-cycle latency).
//   Undefined : purely combinational outputs; those addresses are out of range.
//
// Ports:
//   clk            clock, all state on the rising edge
//   reset          asynchronous active-low reset
//   in_wires       track (s,t) at [(s*NUM_TRACKS+t)*WIDTH +: WIDTH]
//   pe_output      PE output p at [p*WIDTH +: WIDTH]
//   out_wires      same packing as in_wires
//   config_addr    word address for write and readback
//   config_data    write data
//   config_en      write strobe into the shadow bank
//   config_commit  copy shadow into active (includes a same-cycle write)
//   config_rd_data registered readback of shadow[config_addr], 0 if out of range
//
// Config strobes are single-cycle qualifiers with no handshake: a write or a
// commit happens on every rising edge where its strobe is high.
// -----------------------------------------------------------------------------
module sb_param_switch
    import sb_param_pkg::*;
#(
    parameter int NUM_SIDES  = 4,
    parameter int NUM_TRACKS = 4,
    parameter int WIDTH      = 1,
    parameter int NUM_PE     = 1,
    parameter int CFG_AW     = 4
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_SIDES*NUM_TRACKS*WIDTH-1:0] in_wires,
    input  logic [NUM_PE*WIDTH-1:0]             pe_output,
    output logic [NUM_SIDES*NUM_TRACKS*WIDTH-1:0] out_wires,
    input  logic [CFG_AW-1:0]                   config_addr,
    input  logic [31:0]                         config_data,
    input  logic                                config_en,
    input  logic                                config_commit,
    output logic [31:0]                         config_rd_data
);

    localparam int N_OUT       = NUM_SIDES * NUM_TRACKS;
    localparam int N_IN        = sb_n_in(NUM_SIDES, NUM_PE);
    localparam int SEL_W       = sb_sel_w(N_IN);
    localparam int FPW         = sb_fpw(SEL_W);
    localparam int N_SEL_WORDS = sb_n_sel_words(N_OUT, FPW);
`ifdef SB_PIPE_REG_EN
    localparam int N_REG_WORDS = (N_OUT + 31) / 32;
`else
    localparam int N_REG_WORDS = 0;
`endif
    localparam int N_CFG_WORDS = N_SEL_WORDS + N_REG_WORDS;

    // ------------------------------------------------------------------
    // Configuration banks and readback
    // ------------------------------------------------------------------
    logic [31:0] shadow_q [N_CFG_WORDS];
    logic [31:0] shadow_d [N_CFG_WORDS];
    logic [31:0] active_q [N_CFG_WORDS];
    logic [31:0] active_d [N_CFG_WORDS];
    logic [31:0] rd_data_q;
    logic [31:0] rd_data_d;

    always_comb begin
        rd_data_d = '0;
        for (int w = 0; w < N_CFG_WORDS; w++) begin
            shadow_d[w] = shadow_q[w];
            // Out-of-range addresses never match, so they write nothing.
            if (config_en && (32'(config_addr) == 32'(w))) begin
                shadow_d[w] = config_data;
            end
            // Commit takes the post-write shadow so a same-cycle write lands.
            active_d[w] = config_commit ? shadow_d[w] : active_q[w];
            // Readback sees the pre-write shadow; the write shows next read.
            if (32'(config_addr) == 32'(w)) begin
                rd_data_d = shadow_q[w];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int w = 0; w < N_CFG_WORDS; w++) begin
                shadow_q[w] <= '0;
                active_q[w] <= '0;
            end
            rd_data_q <= '0;
        end else begin
            for (int w = 0; w < N_CFG_WORDS; w++) begin
                shadow_q[w] <= shadow_d[w];
                active_q[w] <= active_d[w];
            end
            rd_data_q <= rd_data_d;
        end
    end

    assign config_rd_data = rd_data_q;

    // Upper bits of each word are stored for readback but do not steer anything.
    logic [31:0] active_fold;
    logic        unused_active_bits;

    always_comb begin
        active_fold = '0;
        for (int w = 0; w < N_CFG_WORDS; w++) begin
            active_fold = active_fold ^ active_q[w];
        end
    end

    assign unused_active_bits = ^active_fold;

    // ------------------------------------------------------------------
    // Per-output muxes
    // ------------------------------------------------------------------
    for (genvar o = 0; o < N_OUT; o++) begin : g_out
        localparam int S    = o / NUM_TRACKS;
        localparam int T    = o % NUM_TRACKS;
        localparam int WORD = o / FPW;
        localparam int LSB  = (o % FPW) * SEL_W;

        logic [N_IN*WIDTH-1:0] mux_in;
        logic [SEL_W-1:0]      sel;
        logic [WIDTH-1:0]      mux_out;

        for (genvar i = 0; i < N_IN; i++) begin : g_in
            if (i < NUM_SIDES - 1) begin : g_side
                localparam int SRC =
                    sb_src_side(S, i, NUM_SIDES) * NUM_TRACKS
                    + sb_src_track(S, T, i, NUM_TRACKS);
                assign mux_in[i*WIDTH +: WIDTH] = in_wires[SRC*WIDTH +: WIDTH];
            end else begin : g_pe
                assign mux_in[i*WIDTH +: WIDTH] =
                    pe_output[(i-(NUM_SIDES-1))*WIDTH +: WIDTH];
            end
        end

        assign sel = active_q[WORD][LSB +: SEL_W];

        sb_mux_n #(
            .N     (N_IN),
            .WIDTH (WIDTH),
            .SEL_W (SEL_W)
        ) u_mux (
            .data_i (mux_in),
            .sel_i  (sel),
            .data_o (mux_out)
        );

`ifdef SB_PIPE_REG_EN
        logic             reg_en;
        logic [WIDTH-1:0] pipe_q;
        logic [WIDTH-1:0] pipe_d;

        assign reg_en = active_q[N_SEL_WORDS + o/32][o%32];
        // Register runs regardless of reg_en so switching it on never
        // exposes data older than one cycle.
        assign pipe_d = mux_out;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                pipe_q <= '0;
            end else begin
                pipe_q <= pipe_d;
            end
        end

        assign out_wires[o*WIDTH +: WIDTH] = reg_en ? pipe_q : mux_out;
`else
        assign out_wires[o*WIDTH +: WIDTH] = mux_out;
`endif
    end

endmodule
